rst_seq_ctrl: RTL and testbench

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

---
 rtl/rst_seq_ctrl.sv | 179 +++++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: reset sequencer with programmable hold and a general wait timer.
//
// Purpose
//   Stretches a reset request into an rst_out pulse of a programmable length,
//   and runs a separate down-counting wait that reports completion or abort.
//   A reset request always wins over a wait and cancels a wait in progress.
//
// Configuration
//   RST_SEQ_POWERON_EN : when defined, rst_out is held for DEFAULT_RST_LEN
//                        further cycles after rst deasserts (power-on stretch).
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst        : synchronous active-high reset
//   rst_req    : request a reset hold sequence
//   rst_len    : hold length in cycles (0 selects DEFAULT_RST_LEN)
//   wait_req   : request a wait of wait_num cycles
//   wait_num   : wait length in cycles
//   rst_out    : stretched active-high reset to downstream logic (registered)
//   wait_busy  : high while a wait is counting (registered)
//   wait_done  : one-cycle pulse when a wait completes (registered)
//   wait_abort : one-cycle pulse when a wait is cancelled by rst_req (registered)
module rst_seq_ctrl #(
    parameter int unsigned DEFAULT_RST_LEN = 5,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rst_req,
    input  logic [7:0]       rst_len,
    input  logic             wait_req,
    input  logic [CNT_W-1:0] wait_num,
    output logic             rst_out,
    output logic             wait_busy,
    output logic             wait_done,
    output logic             wait_abort
);

    localparam int unsigned LEN_W   = 8;
    // A zero default would make the hold degenerate; treat it as one cycle.
    localparam int unsigned DEF_LEN = (DEFAULT_RST_LEN == 0) ? 1 : DEFAULT_RST_LEN;
    localparam int unsigned DEF_W   = $clog2(DEF_LEN + 1);
    localparam int unsigned HOLD_W  = (DEF_W > LEN_W) ? DEF_W : LEN_W;
    localparam logic [HOLD_W-1:0] DEF_LOAD = HOLD_W'(DEF_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        WAIT = 2'd2
    } state_e;

    state_e             state_q,      state_d;
    logic [HOLD_W-1:0]  hold_cnt_q,   hold_cnt_d;
    logic [CNT_W-1:0]   wait_cnt_q,   wait_cnt_d;
    logic               rst_out_q,    rst_out_d;
    logic               wait_busy_q,  wait_busy_d;
    logic               wait_done_q,  wait_done_d;
    logic               wait_abort_q, wait_abort_d;
`ifdef RST_SEQ_POWERON_EN
    logic               por_pend_q,   por_pend_d;
`endif

    // Counter load value for a new hold: counters hold remaining cycles minus one,
    // so a load of L-1 yields exactly L cycles of rst_out.
    logic [HOLD_W-1:0]  hold_len_c;
    logic [HOLD_W-1:0]  hold_load_c;

    assign hold_len_c  = (rst_len == 8'd0) ? HOLD_W'(DEF_LEN) : HOLD_W'(rst_len);
    assign hold_load_c = hold_len_c - HOLD_W'(1);

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            rst_out_q    <= 1'b1;
            wait_busy_q  <= 1'b0;
            wait_done_q  <= 1'b0;
            wait_abort_q <= 1'b0;
`ifdef RST_SEQ_POWERON_EN
            por_pend_q   <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            rst_out_q    <= rst_out_d;
            wait_busy_q  <= wait_busy_d;
            wait_done_q  <= wait_done_d;
            wait_abort_q <= wait_abort_d;
`ifdef RST_SEQ_POWERON_EN
            por_pend_q   <= por_pend_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        rst_out_d    = rst_out_q;
        wait_busy_d  = wait_busy_q;
        wait_done_d  = 1'b0;
        wait_abort_d = 1'b0;
`ifdef RST_SEQ_POWERON_EN
        por_pend_d   = por_pend_q;
`endif

        unique case (state_q)
            IDLE: begin
                rst_out_d   = 1'b0;
                wait_busy_d = 1'b0;
`ifdef RST_SEQ_POWERON_EN
                // First cycle out of rst: stretch rst_out by the default length.
                if (por_pend_q) begin
                    por_pend_d = 1'b0;
                    state_d    = HOLD;
                    hold_cnt_d = DEF_LOAD;
                    rst_out_d  = 1'b1;
                end else
`endif
                if (rst_req) begin
                    state_d    = HOLD;
                    hold_cnt_d = hold_load_c;
                    rst_out_d  = 1'b1;
                end else if (wait_req) begin
                    if (wait_num == '0) begin
                        wait_done_d = 1'b1;
                    end else begin
                        state_d     = WAIT;
                        wait_cnt_d  = wait_num - CNT_W'(1);
                        wait_busy_d = 1'b1;
                    end
                end
            end

            HOLD: begin
                rst_out_d = 1'b1;
                if (rst_req) begin
                    hold_cnt_d = hold_load_c;
                end else if (hold_cnt_q == '0) begin
                    state_d   = IDLE;
                    rst_out_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end

            WAIT: begin
                if (rst_req) begin
                    state_d      = HOLD;
                    hold_cnt_d   = hold_load_c;
                    rst_out_d    = 1'b1;
                    wait_cnt_d   = '0;
                    wait_busy_d  = 1'b0;
                    wait_abort_d = 1'b1;
                end else if (wait_cnt_q == '0) begin
                    state_d     = IDLE;
                    wait_busy_d = 1'b0;
                    wait_done_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rst_out    = rst_out_q;
    assign wait_busy  = wait_busy_q;
    assign wait_done  = wait_done_q;
    assign wait_abort = wait_abort_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Table-driven bench for rst_seq_ctrl: each record holds the inputs sampled at
// one rising edge and the outputs expected just after that edge.
module tb_rst_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst_req;
    logic [7:0]  rst_len;
    logic        wait_req;
    logic [15:0] wait_num;
    logic        rst_out;
    logic        wait_busy;
    logic        wait_done;
    logic        wait_abort;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    rst_seq_ctrl #(
        .DEFAULT_RST_LEN(5),
        .CNT_W          (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rst_req   (rst_req),
        .rst_len   (rst_len),
        .wait_req  (wait_req),
        .wait_num  (wait_num),
        .rst_out   (rst_out),
        .wait_busy (wait_busy),
        .wait_done (wait_done),
        .wait_abort(wait_abort)
    );

    typedef struct {
        logic        rst;
        logic        rreq;
        logic [7:0]  rlen;
        logic        wreq;
        logic [15:0] wnum;
        logic [3:0]  exp;   // {rst_out, wait_busy, wait_done, wait_abort}
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic r, input logic rq, input logic [7:0] rl,
                                input logic wq, input logic [15:0] wn, input logic [3:0] e);
        vec_t v;
        v.rst  = r;
        v.rreq = rq;
        v.rlen = rl;
        v.wreq = wq;
        v.wnum = wn;
        v.exp  = e;
        vq.push_back(v);
    endfunction

    // n cycles with no requests, same expected outputs each cycle
    function automatic void idle(input int n, input logic [3:0] e);
        for (int i = 0; i < n; i++) add(1'b0, 1'b0, 8'd0, 1'b0, 16'd0, e);
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got {ro,busy,done,abort}=%b expected %b", name, act, exp);
        end
    endtask

    initial begin
        int busy_cnt;

        rst      = 1'b1;
        rst_req  = 1'b0;
        rst_len  = 8'd0;
        wait_req = 1'b0;
        wait_num = 16'd0;

        // Reset held 3 cycles, requests ignored while rst is high
        add(1'b1, 1'b0, 8'd0, 1'b0, 16'd0, 4'b1000);
        add(1'b1, 1'b1, 8'd7, 1'b0, 16'd0, 4'b1000);
        add(1'b1, 1'b0, 8'd0, 1'b1, 16'd4, 4'b1000);
`ifdef RST_SEQ_POWERON_EN
        idle(5, 4'b1000);
`endif
        idle(2, 4'b0000);

        // rst_req with rst_len=0: five cycles of rst_out
        add(1'b0, 1'b1, 8'd0, 1'b0, 16'd0, 4'b1000);
        idle(4, 4'b1000);
        idle(2, 4'b0000);

        // wait of 3: busy 3 cycles then a single done
        add(1'b0, 1'b0, 8'd0, 1'b1, 16'd3, 4'b0100);
        idle(2, 4'b0100);
        idle(1, 4'b0010);
        idle(1, 4'b0000);

        // wait of 0: immediate done, never busy
        add(1'b0, 1'b0, 8'd0, 1'b1, 16'd0, 4'b0010);
        idle(1, 4'b0000);

        // hold 10, retrigger with 4 on hold cycle 6 -> 10 continuous cycles
        add(1'b0, 1'b1, 8'd10, 1'b0, 16'd0, 4'b1000);
        idle(5, 4'b1000);
        add(1'b0, 1'b1, 8'd4, 1'b0, 16'd0, 4'b1000);
        add(1'b0, 1'b0, 8'd0, 1'b1, 16'd2, 4'b1000);   // wait_req in HOLD is dropped
        idle(2, 4'b1000);
        idle(3, 4'b0000);

        // rst_req and wait_req together: only the hold runs
        add(1'b0, 1'b1, 8'd2, 1'b1, 16'd5, 4'b1000);
        idle(1, 4'b1000);
        idle(3, 4'b0000);

        // wait of 100 aborted by rst_req on wait cycle 20
        add(1'b0, 1'b0, 8'd0, 1'b1, 16'd100, 4'b0100);
        idle(9, 4'b0100);
        add(1'b0, 1'b0, 8'd0, 1'b1, 16'd1, 4'b0100);   // wait_req in WAIT is ignored
        idle(9, 4'b0100);
        add(1'b0, 1'b1, 8'd0, 1'b0, 16'd0, 4'b1001);
        idle(4, 4'b1000);
        idle(3, 4'b0000);

        // rst mid-wait: sequence discarded, no done/abort
        add(1'b0, 1'b0, 8'd0, 1'b1, 16'd5, 4'b0100);
        idle(1, 4'b0100);
        add(1'b1, 1'b1, 8'd3, 1'b1, 16'd2, 4'b1000);
        add(1'b1, 1'b0, 8'd0, 1'b0, 16'd0, 4'b1000);
        add(1'b1, 1'b0, 8'd0, 1'b0, 16'd0, 4'b1000);
`ifdef RST_SEQ_POWERON_EN
        idle(5, 4'b1000);
`endif
        idle(6, 4'b0000);

        // rst mid-hold
        add(1'b0, 1'b1, 8'd20, 1'b0, 16'd0, 4'b1000);
        idle(2, 4'b1000);
        add(1'b1, 1'b0, 8'd0, 1'b0, 16'd0, 4'b1000);
`ifdef RST_SEQ_POWERON_EN
        idle(5, 4'b1000);
`endif
        idle(3, 4'b0000);

        for (int i = 0; i < vq.size(); i++) begin
            rst      = vq[i].rst;
            rst_req  = vq[i].rreq;
            rst_len  = vq[i].rlen;
            wait_req = vq[i].wreq;
            wait_num = vq[i].wnum;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), {rst_out, wait_busy, wait_done, wait_abort}, vq[i].exp);
        end

        // All-ones wait: exactly 65535 busy cycles, no wrap-around
        rst      = 1'b0;
        rst_req  = 1'b0;
        wait_req = 1'b1;
        wait_num = 16'hFFFF;
        @(posedge clk);
        #1;
        wait_req = 1'b0;
        wait_num = 16'd0;
        busy_cnt = 0;
        while (wait_busy === 1'b1 && busy_cnt < 70000) begin
            busy_cnt++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (busy_cnt != 65535) begin
            n_fails++;
            $display("FAIL max_wait_len: got %0d busy cycles expected 65535", busy_cnt);
        end
        check("max_wait_done", {rst_out, wait_busy, wait_done, wait_abort}, 4'b0010);
        @(posedge clk);
        #1;
        check("max_wait_after", {rst_out, wait_busy, wait_done, wait_abort}, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
